// File: rtl/tlb_lookup_pipe.sv
// rtl/tlb_lookup_pipe.sv - multi-port pipelined TLB search with per-port FSM, squash/replay on TLB update
package tlb_lookup_pkg;
  typedef struct packed {
    logic             e;
    logic             g;
    logic [9:0]       asid;
    logic [18:0]      vppn;
    logic [5:0]       ps;
    logic [1:0][31:0] value;
  } tlb_entry_t;

  typedef struct packed {
    logic        dmw;
    logic        found;
    logic [5:0]  index;
    logic [5:0]  ps;
    logic [31:0] value;
  } tlb_s_resp_t;
endpackage

module tlb_lookup_pipe
  import tlb_lookup_pkg::*;
#(
  parameter int TLB_ENTRY_NUM       = 32,
  parameter int PORT_NUM            = 2,
  parameter int TLB_SUPPORT_4M_PAGE = 1,
  parameter int PIPE_STAGES         = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [9:0]                       asid_i,
  input  tlb_entry_t [TLB_ENTRY_NUM-1:0]   entries_i,
  input  logic                             tlb_update_i,
  input  logic                             flush_i,
  input  logic [PORT_NUM-1:0]              req_valid_i,
  output logic [PORT_NUM-1:0]              req_ready_o,
  input  logic [PORT_NUM-1:0][31:0]        vaddr_i,
  output logic [PORT_NUM-1:0]              resp_valid_o,
  input  logic [PORT_NUM-1:0]              resp_ready_i,
  output tlb_s_resp_t [PORT_NUM-1:0]       resp_o,
  output logic [PORT_NUM-1:0]              multihit_o,
  output logic [PORT_NUM-1:0][31:0]        hit_cnt_o,
  output logic [PORT_NUM-1:0][31:0]        miss_cnt_o
);
  typedef enum logic [1:0] {IDLE, LOOKUP, HOLD, REPLAY} state_t;
  typedef logic [TLB_ENTRY_NUM-1:0] match_t;

  localparam tlb_s_resp_t RESP_RST = '{dmw: 1'b0, found: 1'b0, index: 6'd0, ps: 6'd12, value: 32'd0};

  function automatic logic is_4m(input tlb_entry_t ent);
    return (TLB_SUPPORT_4M_PAGE != 0) && (ent.ps != 6'd12);
  endfunction

  function automatic match_t search(input logic [31:0] va, input logic [9:0] asid,
                                    input tlb_entry_t [TLB_ENTRY_NUM-1:0] ent);
    match_t m;
    m = '0;
    for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
      m[i] = ent[i].e && (ent[i].g || (ent[i].asid == asid)) &&
             (is_4m(ent[i]) ? (ent[i].vppn[18:10] == va[31:23]) : (ent[i].vppn == va[31:13]));
    end
    return m;
  endfunction

  // Multi-hit results are the bitwise OR of every matching entry.
  function automatic tlb_s_resp_t encode(input match_t m, input logic [31:0] va,
                                         input tlb_entry_t [TLB_ENTRY_NUM-1:0] ent);
    tlb_s_resp_t r;
    logic        sel;
    r = '0;
    for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
      if (m[i]) begin
        sel      = is_4m(ent[i]) ? va[22] : va[12];
        r.found  = 1'b1;
        r.index  = r.index | 6'(i);
        r.ps     = r.ps | (is_4m(ent[i]) ? 6'd22 : 6'd12);
        r.value  = r.value | ent[i].value[sel];
      end
    end
    if (!r.found) r.ps = 6'd12;
    return r;
  endfunction

  function automatic logic multi(input match_t m);
    return (m & (m - match_t'(1))) != '0;
  endfunction

  // Holds req_ready_o low until the first edge after reset release.
  logic alive;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
    state_t      state;
    logic [31:0] va_q, srch_va, hit_q, miss_q;
    logic [9:0]  asid_q, srch_asid;
    match_t      match_q, srch_match;
    tlb_s_resp_t resp_q, srch_resp, lkp_resp;
    logic        valid_q, multi_q, acc, hs, start, squash, unused_lsb;

    assign req_ready_o[p] = alive && ((state == IDLE) || ((state == HOLD) && resp_ready_i[p]));
    assign acc            = req_valid_i[p] && req_ready_o[p];
    assign hs             = (state == HOLD) && resp_ready_i[p];
    assign start          = acc || (state == REPLAY);
    assign squash         = tlb_update_i && (start || (state == LOOKUP) || ((state == HOLD) && !hs));

    // A replay re-searches the captured request, a fresh accept searches the live one.
    assign srch_va    = (state == REPLAY) ? va_q : vaddr_i[p];
    assign srch_asid  = (state == REPLAY) ? asid_q : asid_i;
    assign srch_match = search(srch_va, srch_asid, entries_i);
    assign srch_resp  = encode(srch_match, srch_va, entries_i);
    assign lkp_resp   = encode(match_q, va_q, entries_i);
    assign unused_lsb = ^srch_va[11:0];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= IDLE;
        va_q    <= '0;
        asid_q  <= '0;
        match_q <= '0;
        resp_q  <= RESP_RST;
        valid_q <= 1'b0;
        multi_q <= 1'b0;
        hit_q   <= '0;
        miss_q  <= '0;
      end else begin
        if (hs && !flush_i) begin
          if (resp_q.found) begin
            if (hit_q != '1) hit_q <= hit_q + 32'd1;
          end else begin
            if (miss_q != '1) miss_q <= miss_q + 32'd1;
          end
        end
        if (acc) begin
          va_q   <= vaddr_i[p];
          asid_q <= asid_i;
        end
        if (flush_i) begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end else if (squash) begin
          state   <= REPLAY;
          valid_q <= 1'b0;
        end else if (start) begin
          if (PIPE_STAGES == 1) begin
            resp_q  <= srch_resp;
            multi_q <= multi(srch_match);
            valid_q <= 1'b1;
            state   <= HOLD;
          end else begin
            match_q <= srch_match;
            valid_q <= 1'b0;
            state   <= LOOKUP;
          end
        end else if (state == LOOKUP) begin
          resp_q  <= lkp_resp;
          multi_q <= multi(match_q);
          valid_q <= 1'b1;
          state   <= HOLD;
        end else if (hs) begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      end
    end

    assign resp_o[p]       = resp_q;
    assign resp_valid_o[p] = valid_q;
    assign multihit_o[p]   = multi_q;
    assign hit_cnt_o[p]    = hit_q;
    assign miss_cnt_o[p]   = miss_q;
  end
endmodule

// File: tb/tb_tlb_lookup_pipe.sv
// tb/tb_tlb_lookup_pipe.sv - directed bench with a transaction-level reference model checked every cycle
module tb_tlb_lookup_pipe;
  import tlb_lookup_pkg::*;

  localparam int N  = 32;
  localparam int P  = 2;
  localparam int PS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [9:0] asid = '0;
  tlb_entry_t [N-1:0] ents;
  logic upd = 1'b0, flush = 1'b0;
  logic [P-1:0] req_valid = '0, resp_ready = '0;
  logic [P-1:0] req_ready, resp_valid, multihit;
  logic [P-1:0][31:0] vaddr = '0;
  logic [P-1:0][31:0] hit_cnt, miss_cnt;
  tlb_s_resp_t [P-1:0] resp;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tlb_lookup_pipe #(.TLB_ENTRY_NUM(N), .PORT_NUM(P), .TLB_SUPPORT_4M_PAGE(1), .PIPE_STAGES(PS)) dut (
    .clk(clk), .rst_n(rst_n), .asid_i(asid), .entries_i(ents), .tlb_update_i(upd), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .vaddr_i(vaddr), .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready), .resp_o(resp), .multihit_o(multihit), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic tlb_entry_t mk(input bit e, input bit g, input logic [9:0] a, input logic [18:0] vppn,
                                    input logic [5:0] ps, input logic [31:0] v0, input logic [31:0] v1);
    tlb_entry_t t;
    t.e = e; t.g = g; t.asid = a; t.vppn = vppn; t.ps = ps;
    t.value[0] = v0; t.value[1] = v1;
    return t;
  endfunction

  // Reference search written straight from the page-matching rules.
  function automatic void ref_lookup(input logic [31:0] va, input logic [9:0] a,
                                     output tlb_s_resp_t r, output bit mh);
    int nhit;
    bit big, hit;
    logic [5:0] psacc;
    nhit = 0; psacc = 0; r = '0;
    for (int i = 0; i < N; i++) begin
      big = (ents[i].ps != 6'd12);
      hit = ents[i].e && (ents[i].g || ents[i].asid == a) &&
            (big ? (ents[i].vppn[18:10] == va[31:23]) : (ents[i].vppn == va[31:13]));
      if (hit) begin
        nhit++;
        r.found = 1'b1;
        r.index = r.index | 6'(i);
        psacc = psacc | (big ? 6'd22 : 6'd12);
        r.value = r.value | ents[i].value[big ? va[22] : va[12]];
      end
    end
    r.ps = (nhit > 0) ? psacc : 6'd12;
    mh = (nhit >= 2);
  endfunction

  // Port model: idle, busy with cycles remaining, or holding a result.
  bit m_alive;
  bit m_busy[P], m_hold[P], m_multi[P];
  int m_rem[P];
  logic [31:0] m_va[P], m_hit[P], m_miss[P];
  logic [9:0] m_asid[P];
  tlb_s_resp_t m_res[P];

  function automatic bit m_ready(input int p);
    return m_alive && ((!m_busy[p] && !m_hold[p]) || (m_hold[p] && resp_ready[p]));
  endfunction

  task automatic model_step();
    bit acc, hs;
    if (!rst_n) begin
      m_alive = 0;
      for (int p = 0; p < P; p++) begin
        m_busy[p] = 0; m_hold[p] = 0; m_hit[p] = 0; m_miss[p] = 0;
      end
      return;
    end
    for (int p = 0; p < P; p++) begin
      acc = req_valid[p] && m_ready(p);
      hs  = m_hold[p] && resp_ready[p];
      if (flush) begin
        m_busy[p] = 0; m_hold[p] = 0;
        continue;
      end
      if (hs) begin
        if (m_res[p].found) begin if (m_hit[p] != 32'hFFFF_FFFF) m_hit[p]++; end
        else begin if (m_miss[p] != 32'hFFFF_FFFF) m_miss[p]++; end
        m_hold[p] = 0;
      end
      if (m_hold[p] && upd) begin
        m_hold[p] = 0; m_busy[p] = 1; m_rem[p] = PS + 1;
      end
      if (acc) begin
        m_busy[p] = 1; m_rem[p] = PS; m_va[p] = vaddr[p]; m_asid[p] = asid;
      end
      if (m_busy[p] && upd) m_rem[p] = PS + 1;
      if (m_busy[p]) begin
        m_rem[p]--;
        if (m_rem[p] == 0) begin
          ref_lookup(m_va[p], m_asid[p], m_res[p], m_multi[p]);
          m_hold[p] = 1; m_busy[p] = 0;
        end
      end
    end
    m_alive = 1;
  endtask

  task automatic compare();
    for (int p = 0; p < P; p++) begin
      chk($sformatf("req_ready[%0d]", p), 64'(req_ready[p]), 64'(m_ready(p)));
      chk($sformatf("resp_valid[%0d]", p), 64'(resp_valid[p]), 64'(m_hold[p]));
      if (m_hold[p]) begin
        chk($sformatf("resp[%0d]", p), 64'(resp[p]), 64'(m_res[p]));
        chk($sformatf("multihit[%0d]", p), 64'(multihit[p]), 64'(m_multi[p]));
      end
      chk($sformatf("hit_cnt[%0d]", p), 64'(hit_cnt[p]), 64'(m_hit[p]));
      chk($sformatf("miss_cnt[%0d]", p), 64'(miss_cnt[p]), 64'(m_miss[p]));
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (rst_n) compare();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input int p, input logic [31:0] va, input logic [9:0] a, output int lat);
    int k;
    @(negedge clk);
    req_valid[p] = 1'b1; vaddr[p] = va; asid = a;
    #1;
    k = 0;
    while (!req_ready[p] && k < 20) begin @(negedge clk); #1; k++; end
    if (k >= 20) chk("accept timeout", 64'(req_ready[p]), 64'd1);
    @(negedge clk);
    req_valid[p] = 1'b0;
    lat = 1;
    while (!resp_valid[p] && lat < 20) begin @(negedge clk); lat++; end
    if (lat >= 20) chk("response timeout", 64'(resp_valid[p]), 64'd1);
  endtask

  task automatic wait_valid(input int p, output int n);
    n = 1;
    while (!resp_valid[p] && n < 20) begin @(negedge clk); n++; end
  endtask

  localparam tlb_s_resp_t RESP_RST = '{dmw: 1'b0, found: 1'b0, index: 6'd0, ps: 6'd12, value: 32'd0};
  tlb_entry_t e5;
  logic [31:0] bva[6];
  logic [9:0]  basid[6];

  initial begin
    tlb_s_resp_t r;
    bit mh;
    int lat, n, k;
    logic [31:0] sv_hit[P], sv_miss[P];

    e5 = mk(1, 1, 10'd0, 19'h00012, 6'd12, 32'hAAAA_0005, 32'hBBBB_0005);
    ents = '0;
    ents[0]  = mk(1, 1, 10'd0,   19'h7FFFF, 6'd12, 32'hA0A0_0000, 32'hA0A0_0001);
    ents[2]  = mk(1, 1, 10'd0,   19'h00100, 6'd12, 32'h0000_00F0, 32'h0000_00F0);
    ents[3]  = mk(1, 1, 10'd0,   19'h00100, 6'd12, 32'h0000_0F00, 32'h0000_0F00);
    ents[5]  = e5;
    ents[9]  = mk(1, 0, 10'd3,   19'h0A400, 6'd22, 32'hCCCC_0009, 32'hDDDD_0009);
    ents[31] = mk(1, 0, 10'h3FF, 19'h40000, 6'd12, 32'h3131_0000, 32'h3131_0001);

    ref_lookup(32'h0002_5000, 10'd0, r, mh);
    chk("model 4k hit", 64'(r), 64'({1'b0, 1'b1, 6'd5, 6'd12, 32'hBBBB_0005}));
    ref_lookup(32'h14BF_F000, 10'd3, r, mh);
    chk("model 4m hit", 64'(r), 64'({1'b0, 1'b1, 6'd9, 6'd22, 32'hCCCC_0009}));
    ref_lookup(32'h14BF_F000, 10'd4, r, mh);
    chk("model asid miss", 64'(r), 64'(RESP_RST));
    ref_lookup(32'h0020_0000, 10'd0, r, mh);
    chk("model multihit", 64'({mh, r.index, r.value}), 64'({1'b1, 6'd3, 32'h0000_0FF0}));

    repeat (3) @(negedge clk);
    for (int p = 0; p < P; p++) begin
      chk("reset req_ready", 64'(req_ready[p]), 64'd0);
      chk("reset resp_valid", 64'(resp_valid[p]), 64'd0);
      chk("reset multihit", 64'(multihit[p]), 64'd0);
      chk("reset resp", 64'(resp[p]), 64'(RESP_RST));
      chk("reset counters", {hit_cnt[p], miss_cnt[p]}, 64'd0);
    end
    rst_n = 1'b1;
    resp_ready = 2'b11;
    @(negedge clk);
    chk("ready after reset", 64'(req_ready), 64'(2'b11));

    // 4K hit, odd half selected by vaddr[12]
    send(0, 32'h0002_5000, 10'd0, lat);
    chk("4k latency", 64'(lat), 64'(PS));
    chk("4k resp", 64'(resp[0]), 64'({1'b0, 1'b1, 6'd5, 6'd12, 32'hBBBB_0005}));
    @(negedge clk);
    chk("4k hit_cnt", 64'(hit_cnt[0]), 64'd1);

    // 4M page: asid match then mismatch
    send(0, 32'h14BF_F000, 10'd3, lat);
    chk("4m resp", 64'(resp[0]), 64'({1'b0, 1'b1, 6'd9, 6'd22, 32'hCCCC_0009}));
    send(0, 32'h14BF_F000, 10'd4, lat);
    chk("4m asid miss", 64'(resp[0]), 64'(RESP_RST));
    @(negedge clk);
    chk("4m counters", {hit_cnt[0], miss_cnt[0]}, {32'd2, 32'd1});

    // Two entries matching on port 1
    send(1, 32'h0020_0000, 10'd0, lat);
    chk("multihit flag", 64'(multihit[1]), 64'd1);
    chk("multihit resp", 64'(resp[1]), 64'({1'b0, 1'b1, 6'd3, 6'd12, 32'h0000_0FF0}));

    // Back-to-back burst on port 0 with the response always accepted
    bva = '{32'hFFFF_F000, 32'h8000_0000, 32'h8000_0000, 32'h1481_2000, 32'h0020_0000, 32'h1234_5000};
    basid = '{10'd0, 10'h3FF, 10'd0, 10'd3, 10'd7, 10'd1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_valid[0] = 1'b1; vaddr[0] = bva[i]; asid = basid[i];
      #1;
      k = 0;
      while (!req_ready[0] && k < 20) begin @(negedge clk); #1; k++; end
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (PS + 2) @(negedge clk);
    chk("burst counters", {hit_cnt[0], miss_cnt[0]}, {32'd6, 32'd3});

    // Update during HOLD removes the entry; result replays as a miss
    resp_ready[0] = 1'b0;
    send(0, 32'h0002_5000, 10'd0, lat);
    chk("hold found", 64'(resp[0].found), 64'd1);
    @(negedge clk);
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    ents[5].e = 1'b0;
    chk("squash drops valid", 64'(resp_valid[0]), 64'd0);
    wait_valid(0, n);
    chk("replay latency", 64'(n), 64'(PS + 1));
    chk("replay resp", 64'(resp[0]), 64'(RESP_RST));
    @(negedge clk);
    resp_ready[0] = 1'b1;
    @(negedge clk);
    chk("replay counters", {hit_cnt[0], miss_cnt[0]}, {32'd6, 32'd4});

    @(negedge clk);
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    ents[5] = e5;

    // Handshake with update in the same cycle keeps old result; port 1 accept is replayed
    resp_ready[0] = 1'b0;
    send(0, 32'h0002_5000, 10'd0, lat);
    @(negedge clk);
    resp_ready[0] = 1'b1; upd = 1'b1;
    req_valid[1] = 1'b1; vaddr[1] = 32'h0002_5000; asid = 10'd0;
    @(negedge clk);
    upd = 1'b0; req_valid[1] = 1'b0;
    ents[5].e = 1'b0;
    chk("old result counted", 64'(hit_cnt[0]), 64'd7);
    chk("port0 idle after hs", 64'(resp_valid[0]), 64'd0);
    wait_valid(1, n);
    chk("accept-replay latency", 64'(n), 64'(PS + 1));
    chk("accept-replay found", 64'(resp[1].found), 64'd0);
    @(negedge clk);
    chk("port1 miss_cnt", 64'(miss_cnt[1]), 64'd1);

    // Flush while both ports are in LOOKUP
    for (int p = 0; p < P; p++) begin sv_hit[p] = hit_cnt[p]; sv_miss[p] = miss_cnt[p]; end
    @(negedge clk);
    req_valid = 2'b11; vaddr[0] = 32'h0020_0000; vaddr[1] = 32'h0020_0000; asid = 10'd0;
    @(negedge clk);
    req_valid = 2'b00; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("flush no response", 64'(resp_valid), 64'd0);
    end
    for (int p = 0; p < P; p++)
      chk("flush counters kept", {hit_cnt[p], miss_cnt[p]}, {sv_hit[p], sv_miss[p]});
    send(1, 32'h0020_0000, 10'd0, lat);
    chk("post-flush latency", 64'(lat), 64'(PS));
    chk("post-flush found", 64'(resp[1].found), 64'd1);

    // Reset while port 0 is mid-lookup
    @(negedge clk);
    req_valid[0] = 1'b1; vaddr[0] = 32'h0020_0000;
    @(negedge clk);
    req_valid[0] = 1'b0; rst_n = 1'b0;
    #1;
    chk("mid reset ready", 64'(req_ready), 64'd0);
    chk("mid reset valid", 64'(resp_valid), 64'd0);
    chk("mid reset resp0", 64'(resp[0]), 64'(RESP_RST));
    chk("mid reset counters", {hit_cnt[0], miss_cnt[1]}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no response after reset", 64'(resp_valid), 64'd0);
    end
    chk("ready after mid reset", 64'(req_ready), 64'(2'b11));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
